// File: rtl/mant_div_pkg.sv
// Shared constants and state encoding for the sequential mantissa divider.
// Optional early termination is enabled by defining MANT_DIV_EARLY_EXIT_EN.
package mant_div_pkg;
  localparam int W_MANT  = 24;
  localparam int QW_MANT = 26;
  localparam int CNT_W   = $clog2(QW_MANT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mant_sub_step.sv
// Borrow-chain subtractor built from 8-bit full-subtractor slices.
// Inputs are zero-extended to a whole number of slices; cout is the final borrow.
module mant_sub_slice8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);
  logic [8:0] bw;

  always_comb begin
    bw    = '0;
    d     = '0;
    bw[0] = bin;
    for (int i = 0; i < 8; i++) begin
      d[i]    = a[i] ^ b[i] ^ bw[i];
      bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
  end

  assign bout = bw[8];
endmodule

module mant_sub_step
  import mant_div_pkg::*;
#(
  parameter int WIDTH = W_MANT + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);
  localparam int NSLICE = (WIDTH + 7) / 8;
  localparam int EXT    = NSLICE * 8;

  logic [EXT-1:0] a_ext, b_ext, d_ext;
  logic [NSLICE:0] bchain;

  assign a_ext     = EXT'(a);
  assign b_ext     = EXT'(b);
  assign bchain[0] = 1'b0;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    mant_sub_slice8 u_slice (
      .a    (a_ext[s*8 +: 8]),
      .b    (b_ext[s*8 +: 8]),
      .bin  (bchain[s]),
      .d    (d_ext[s*8 +: 8]),
      .bout (bchain[s+1])
    );
  end

  // Padding bits only mirror the borrow; the chain's last borrow is the result.
  if (EXT > WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^d_ext[EXT-1:WIDTH];
  end

  assign diff = d_ext[WIDTH-1:0];
  assign cout = bchain[NSLICE];
endmodule

// File: rtl/mant_div_seq.sv
// Restoring mantissa divider: one quotient bit per cycle plus a sticky bit.
// Define MANT_DIV_EARLY_EXIT_EN to finish as soon as the remainder reaches zero.
module mant_div_seq
  import mant_div_pkg::*;
#(
  parameter int W  = W_MANT,
  parameter int QW = QW_MANT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          div_by_zero,
  output logic [1:0]    dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid/ready never depend combinationally on the other side's signal.
  state_t           state_q, state_d;
  logic [W:0]       rem_q, rem_d, dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    quot_q, quot_d;
  logic             sticky_q, sticky_d;
  logic             dbz_q, dbz_d;

  logic [W:0]       diff, rem_shift;
  logic             borrow;
  logic [QW-1:0]    quot_shift;

  mant_sub_step #(.WIDTH(W + 1)) u_sub (
    .a    (rem_q),
    .b    (dsr_q),
    .diff (diff),
    .cout (borrow)
  );

  // Precondition rem < 2*dsr keeps both shifted candidates within W+1 bits.
  assign rem_shift  = borrow ? {rem_q[W-1:0], 1'b0} : {diff[W-1:0], 1'b0};
  assign quot_shift = {quot_q[QW-2:0], ~borrow};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quot_d   = '1;
            sticky_d = 1'b0;
            dbz_d    = 1'b1;
            state_d  = DONE;
          end else begin
            rem_d    = {1'b0, dividend};
            dsr_d    = {1'b0, divisor};
            cnt_d    = CNT_W'(QW);
            quot_d   = '0;
            sticky_d = 1'b0;
            dbz_d    = 1'b0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = rem_shift;
        quot_d = quot_shift;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          sticky_d = |rem_shift;
          state_d  = DONE;
        end
`ifdef MANT_DIV_EARLY_EXIT_EN
        else if (rem_shift == '0) begin
          quot_d   = quot_shift << (cnt_q - 1'b1);
          sticky_d = 1'b0;
          state_d  = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign sticky      = sticky_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

`ifndef SYNTHESIS
  a_norm_operands: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready && divisor != '0) |-> ({1'b0, dividend} < {divisor, 1'b0}));
`endif
endmodule

// File: tb/tb_mant_div_seq.sv
// Directed bench for mant_div_seq: vector table plus handshake/reset sequences.
module tb_mant_div_seq;
  localparam int W  = 24;
  localparam int QW = 26;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic          sticky;
  logic          div_by_zero;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [QW-1:0] q;
    logic          st;
  } vec_t;

  vec_t vecs[8];

  mant_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .sticky      (sticky),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: out_valid=0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_latency(input string name, input int lat);
`ifdef MANT_DIV_EARLY_EXIT_EN
    check(name, 32'(lat <= QW), 32'd1);
`else
    check(name, 32'(lat), 32'(QW));
`endif
  endtask

  initial begin
    int lat;
    logic [QW-1:0] held_q;

    vecs[0] = '{dvd: 24'h800000, dvs: 24'h800000, q: 26'h2000000, st: 1'b0};
    vecs[1] = '{dvd: 24'hC00000, dvs: 24'h800000, q: 26'h3000000, st: 1'b0};
    vecs[2] = '{dvd: 24'h800000, dvs: 24'hC00000, q: 26'h1555555, st: 1'b1};
    vecs[3] = '{dvd: 24'hFFFFFF, dvs: 24'h800000, q: 26'h3FFFFFC, st: 1'b0};
    vecs[4] = '{dvd: 24'h800000, dvs: 24'hFFFFFF, q: 26'h1000001, st: 1'b1};
    vecs[5] = '{dvd: 24'hA00000, dvs: 24'h800000, q: 26'h2800000, st: 1'b0};
    vecs[6] = '{dvd: 24'h900000, dvs: 24'hC00000, q: 26'h1800000, st: 1'b0};
    vecs[7] = '{dvd: 24'hC00000, dvs: 24'hC00000, q: 26'h2000000, st: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Divide by zero: result in the cycle right after the accept edge
    start_op(24'h900000, 24'h000000);
    wait_done(lat);
    check("dbz_latency", 32'(lat), 32'd0);
    check("dbz_flag", 32'(div_by_zero), 32'd1);
    check("dbz_quotient", 32'(quotient), 32'h3FFFFFF);
    check("dbz_sticky", 32'(sticky), 32'd0);
    release_op();

    // Vector table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].q);
      start_op(vecs[i].dvd, vecs[i].dvs);
      wait_done(lat);
      check_latency($sformatf("vec%0d_latency", i), lat);
      check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(exp_q.pop_front()));
      check($sformatf("vec%0d_sticky", i), 32'(sticky), 32'(vecs[i].st));
      check($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'd0);
      release_op();
    end

    // Backpressure: hold results while out_ready is low, ignore new requests
    start_op(24'hC00000, 24'h800000);
    wait_done(lat);
    held_q = 26'h3000000;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      dividend = 24'h800000;
      divisor  = 24'h000000;
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_quotient", c), 32'(quotient), 32'(held_q));
      check($sformatf("bp%0d_dbz", c), 32'(div_by_zero), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_out_valid", 32'(out_valid), 32'd0);
    check("bp_after_in_ready", 32'(in_ready), 32'd1);
    start_op(24'h800000, 24'h800000);
    wait_done(lat);
    check("bp_next_quotient", 32'(quotient), 32'h2000000);
    check("bp_next_dbz", 32'(div_by_zero), 32'd0);
    release_op();

    // Mid-operation reset on iteration 10
    start_op(24'h800000, 24'hC00000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    start_op(24'hC00000, 24'h800000);
    wait_done(lat);
    check_latency("post_rst_latency", lat);
    check("post_rst_quotient", 32'(quotient), 32'h3000000);
    check("post_rst_sticky", 32'(sticky), 32'd0);
    release_op();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
